// File: rtl/gs_raw_frame_packer.sv
// Frames the raw sample stream into header / payload / checksum / trailer words for the host FIFO.
// Optional build macro GS_PACK_SEQ_EN adds a per-frame sequence word after the header.
module gs_raw_frame_packer #(
  parameter int unsigned BUF_DEPTH = 16,
  parameter logic [15:0] SYNC_HEAD = 16'hA55A,
  parameter logic [15:0] SYNC_TAIL = 16'h5AA5
) (
  input  logic        iClk,
  input  logic        iReset,
  input  logic        iRegAcCmd,
  input  logic [31:0] i32Cmd,
  input  logic        iWriteRawSignal,
  input  logic [15:0] i16RawSignal,
  input  logic        iFifoFull,
  output logic [15:0] o16FifoData,
  output logic        oFifoWren,
  output logic        oBusy,
  output logic        oDropErr
);

  localparam int unsigned AW = $clog2(BUF_DEPTH);
  localparam logic [AW:0] FullCnt = (AW + 1)'(BUF_DEPTH);

  // Each state names the word currently held in the output register.
  typedef enum logic [2:0] {
    StIdle, StHdr0, StHdr1, StHdr2, StSeq, StData, StSum, StTail
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] cmd_q;
  logic [15:0] in_rem_q;
  logic [15:0] out_rem_q, out_rem_d;
  logic [15:0] sum_q, sum_d;
  logic [15:0] out_q, out_d;
  logic        valid_q, valid_d;
  logic        drop_q;
  logic        start;
  logic        load_payload;
  logic        pop;
  logic        accept;
  logic        wren;
  logic        slot_free;
  logic        busy;

  logic [15:0] buf_mem [BUF_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic          buf_full, buf_empty;

`ifdef GS_PACK_SEQ_EN
  logic [15:0] seq_q;
  logic        seq_inc;
`endif

  assign busy      = (state_q != StIdle);
  assign wren      = valid_q & ~iFifoFull;
  assign slot_free = ~valid_q | wren;
  assign buf_full  = (count_q == FullCnt);
  assign buf_empty = (count_q == '0);
  assign accept    = iWriteRawSignal & busy & (in_rem_q != 16'd0) & ~buf_full;

  assign o16FifoData = out_q;
  assign oFifoWren   = wren;
  assign oBusy       = busy;
  assign oDropErr    = drop_q;

  always_comb begin
    state_d      = state_q;
    out_d        = out_q;
    valid_d      = valid_q & ~wren;
    sum_d        = sum_q;
    out_rem_d    = out_rem_q;
    pop          = 1'b0;
    start        = 1'b0;
    load_payload = 1'b0;
`ifdef GS_PACK_SEQ_EN
    seq_inc      = 1'b0;
`endif
    unique case (state_q)
      StIdle: begin
        if (iRegAcCmd) begin
          start     = 1'b1;
          out_d     = SYNC_HEAD;
          valid_d   = 1'b1;
          sum_d     = 16'd0;
          out_rem_d = i32Cmd[15:0];
          state_d   = StHdr0;
        end
      end
      StHdr0: begin
        if (wren) begin
          out_d   = cmd_q[31:16];
          valid_d = 1'b1;
          sum_d   = sum_q + cmd_q[31:16];
          state_d = StHdr1;
        end
      end
      StHdr1: begin
        if (wren) begin
          out_d   = cmd_q[15:0];
          valid_d = 1'b1;
          sum_d   = sum_q + cmd_q[15:0];
          state_d = StHdr2;
        end
      end
      StHdr2: begin
        if (wren) begin
`ifdef GS_PACK_SEQ_EN
          out_d   = seq_q;
          valid_d = 1'b1;
          sum_d   = sum_q + seq_q;
          state_d = StSeq;
`else
          load_payload = 1'b1;
`endif
        end
      end
      StSeq:  load_payload = wren;
      StData: load_payload = slot_free;
      StSum: begin
        if (wren) begin
          out_d   = SYNC_TAIL;
          valid_d = 1'b1;
          state_d = StTail;
        end
      end
      StTail: begin
        if (wren) begin
          state_d = StIdle;
`ifdef GS_PACK_SEQ_EN
          seq_inc = 1'b1;
`endif
        end
      end
      default: state_d = StIdle;
    endcase

    // Shared by every state that hands over to the payload: next sample, or the checksum.
    if (load_payload) begin
      if (out_rem_q != 16'd0) begin
        state_d = StData;
        if (!buf_empty) begin
          out_d     = buf_mem[rd_ptr_q];
          valid_d   = 1'b1;
          pop       = 1'b1;
          sum_d     = sum_q + buf_mem[rd_ptr_q];
          out_rem_d = out_rem_q - 16'd1;
        end
      end else begin
        out_d   = sum_q;
        valid_d = 1'b1;
        state_d = StSum;
      end
    end
  end

  always_ff @(posedge iClk or posedge iReset) begin
    if (iReset) begin
      state_q   <= StIdle;
      cmd_q     <= 32'd0;
      in_rem_q  <= 16'd0;
      out_rem_q <= 16'd0;
      sum_q     <= 16'd0;
      out_q     <= 16'd0;
      valid_q   <= 1'b0;
      drop_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      out_rem_q <= out_rem_d;
      sum_q     <= sum_d;
      out_q     <= out_d;
      valid_q   <= valid_d;
      if (start) begin
        cmd_q    <= i32Cmd;
        in_rem_q <= i32Cmd[15:0];
      end else if (accept) begin
        in_rem_q <= in_rem_q - 16'd1;
      end
      if ((iWriteRawSignal & ~accept) | (iRegAcCmd & busy)) begin
        drop_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge iClk or posedge iReset) begin
    if (iReset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (accept) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)    rd_ptr_q <= rd_ptr_q + 1'b1;
      if (accept && !pop) begin
        count_q <= count_q + 1'b1;
      end else if (pop && !accept) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

  always_ff @(posedge iClk) begin
    if (accept) buf_mem[wr_ptr_q] <= i16RawSignal;
  end

`ifdef GS_PACK_SEQ_EN
  always_ff @(posedge iClk or posedge iReset) begin
    if (iReset) begin
      seq_q <= 16'd0;
    end else if (seq_inc) begin
      seq_q <= seq_q + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_gs_raw_frame_packer.sv
// Directed bench for gs_raw_frame_packer; frame contents rebuilt from cmd and sample lists.
module tb_gs_raw_frame_packer;

  logic        clk = 1'b0;
  logic        rst;
  logic        acc;
  logic [31:0] cmd;
  logic        wr;
  logic [15:0] raw;
  logic        full;
  logic [15:0] fifo_data;
  logic        fifo_wren;
  logic        busy;
  logic        drop_err;

  int n_checks = 0;
  int n_errors = 0;

  logic [15:0] got_q[$];
  logic [15:0] exp_q[$];
  logic [15:0] samp_q[$];
  logic [15:0] seq_exp;

  logic        mon_en = 1'b0;
  int          viol = 0;
  logic        prev_full = 1'b0;
  logic [15:0] prev_data = 16'd0;

  gs_raw_frame_packer dut (
    .iClk           (clk),
    .iReset         (rst),
    .iRegAcCmd      (acc),
    .i32Cmd         (cmd),
    .iWriteRawSignal(wr),
    .i16RawSignal   (raw),
    .iFifoFull      (full),
    .o16FifoData    (fifo_data),
    .oFifoWren      (fifo_wren),
    .oBusy          (busy),
    .oDropErr       (drop_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (fifo_wren) got_q.push_back(fifo_data);
  end

  // Output word must not move while the FIFO stays full.
  always @(posedge clk) begin
    if (mon_en && prev_full && full && fifo_data != prev_data) viol <= viol + 1;
    prev_full <= full;
    prev_data <= fifo_data;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [31:0] c);
    cmd = c;
    acc = 1'b1;
    tick();
    acc = 1'b0;
  endtask

  task automatic push(input logic [15:0] v);
    wr  = 1'b1;
    raw = v;
    tick();
    wr  = 1'b0;
  endtask

  task automatic wait_idle(input int max, input string tag);
    int k = 0;
    while (busy && k < max) begin
      tick();
      k++;
    end
    check(tag, {31'd0, busy}, 32'd0);
  endtask

  task automatic wait_words(input int n, input int max);
    int k = 0;
    while (got_q.size() < n && k < max) begin
      tick();
      k++;
    end
    check("wait_words", got_q.size(), n);
  endtask

  // Appends one expected frame built from cmd, samp_q and a sequence value.
  task automatic add_exp(input logic [31:0] c, input logic [15:0] seq);
    logic [15:0] sum;
    sum = c[31:16] + c[15:0];
    exp_q.push_back(16'hA55A);
    exp_q.push_back(c[31:16]);
    exp_q.push_back(c[15:0]);
`ifdef GS_PACK_SEQ_EN
    exp_q.push_back(seq);
    sum = sum + seq;
`endif
    foreach (samp_q[i]) begin
      exp_q.push_back(samp_q[i]);
      sum = sum + samp_q[i];
    end
    exp_q.push_back(sum);
    exp_q.push_back(16'h5AA5);
  endtask

  task automatic cmp_frame(input string tag);
    check($sformatf("%s_len", tag), got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < got_q.size()) check($sformatf("%s_w%0d", tag, i), got_q[i], exp_q[i]);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    seq_exp = 16'd0;
    got_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; acc = 1'b0; cmd = 32'd0; wr = 1'b0; raw = 16'd0; full = 1'b0;
    seq_exp = 16'd0;
    #12;
    check("rst_data", fifo_data, 32'd0);
    check("rst_wren", fifo_wren, 32'd0);
    check("rst_busy", busy, 32'd0);
    check("rst_drop", drop_err, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    tick();

    // 1: three samples, checksum 0102+0003+000A+0014+001E = 0141
    got_q.delete(); exp_q.delete();
    samp_q = '{16'h000A, 16'h0014, 16'h001E};
    pulse(32'h0102_0003);
    foreach (samp_q[i]) push(samp_q[i]);
    wait_idle(50, "t1_done");
    add_exp(32'h0102_0003, seq_exp);
    cmp_frame("t1");
    check("t1_sum", (got_q.size() >= 2) ? got_q[got_q.size()-2] : 16'h0, 16'h0141);
    check("t1_drop", drop_err, 32'd0);
    seq_exp++;

    // 2: empty payload
    got_q.delete(); exp_q.delete(); samp_q.delete();
    pulse(32'hBEEF_0000);
    wait_idle(50, "t2_done");
    add_exp(32'hBEEF_0000, seq_exp);
    cmp_frame("t2");
    seq_exp++;

    // 3: FIFO full for 40 cycles with the third sample held in the output register
    got_q.delete(); exp_q.delete();
    samp_q = '{16'h0101, 16'h0202, 16'h0303, 16'h0404,
               16'h0505, 16'h0606, 16'h0707, 16'h0808};
    pulse(32'h00AA_0008);
    for (int i = 0; i < 4; i++) push(samp_q[i]);
`ifdef GS_PACK_SEQ_EN
    wait_words(6, 50);
`else
    wait_words(5, 50);
`endif
    full = 1'b1;
    mon_en = 1'b1;
    for (int i = 4; i < 8; i++) push(samp_q[i]);
    repeat (36) tick();
    check("t3_hold", fifo_data, 16'h0303);
    check("t3_stable", viol, 32'd0);
    full = 1'b0;
    mon_en = 1'b0;
    wait_idle(80, "t3_done");
    add_exp(32'h00AA_0008, seq_exp);
    cmp_frame("t3");
    check("t3_drop", drop_err, 32'd0);
    seq_exp++;
    do_reset();

    // 4: 17 samples into a 16-deep buffer while the FIFO is full
    full = 1'b1;
    pulse(32'h0000_0011);
    for (int i = 0; i < 16; i++) push(16'h0100 + 16'(i));
    check("t4_drop_pre", drop_err, 32'd0);
    push(16'h0110);
    check("t4_drop", drop_err, 32'd1);
    check("t4_none_out", got_q.size(), 32'd0);
    full = 1'b0;
    repeat (40) tick();
`ifdef GS_PACK_SEQ_EN
    check("t4_words", got_q.size(), 32'd20);
`else
    check("t4_words", got_q.size(), 32'd19);
`endif
    check("t4_last", (got_q.size() > 0) ? got_q[got_q.size()-1] : 16'h0, 16'h010F);
    check("t4_busy", busy, 32'd1);
    do_reset();
    check("t4_reset_drop", drop_err, 32'd0);

    // Stray strobe outside a frame
    push(16'h1234);
    check("stray_drop", drop_err, 32'd1);
    do_reset();

    // Command while busy is ignored but flagged
    got_q.delete(); exp_q.delete();
    samp_q = '{16'h0777};
    pulse(32'h0005_0001);
    pulse(32'hFFFF_FFFF);
    check("dup_drop", drop_err, 32'd1);
    push(16'h0777);
    wait_idle(50, "dup_done");
    add_exp(32'h0005_0001, seq_exp);
    cmp_frame("dup");
    do_reset();

    // 5: reset after the second header word leaves the FIFO
    pulse(32'h0033_0001);
    wait_words(2, 20);
    rst = 1'b1;
    #2;
    check("t5_data", fifo_data, 32'd0);
    check("t5_wren", fifo_wren, 32'd0);
    check("t5_busy", busy, 32'd0);
    tick();
    rst = 1'b0;
    tick();
    seq_exp = 16'd0;
    got_q.delete(); exp_q.delete();
    samp_q = '{16'h4242};
    pulse(32'h0044_0001);
    push(16'h4242);
    wait_idle(50, "t5_done");
    add_exp(32'h0044_0001, seq_exp);
    cmp_frame("t5");
    seq_exp++;
    do_reset();

    // 6: two frames back to back
    exp_q.delete();
    samp_q = '{16'h0005};
    pulse(32'h0001_0001);
    push(16'h0005);
    wait_idle(50, "t6a_done");
    add_exp(32'h0001_0001, seq_exp);
    seq_exp++;
    pulse(32'h0001_0001);
    push(16'h0005);
    wait_idle(50, "t6b_done");
    add_exp(32'h0001_0001, seq_exp);
    seq_exp++;
    cmp_frame("t6");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
